fp_subtract_seq: RTL and testbench

//  Multi-cycle IEEE-754 single-precision subtractor: result = A - B. Inverse operation of the

---
 rtl/fp_pkg.sv | 22 ++
 rtl/fp_align_shift.sv | 10 +
 rtl/fp_subtract_seq.sv | 105 ++++++++++
 tb/tb_fp_subtract_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared single-precision field widths, slicing helpers and subtractor FSM states.
package fp_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int FP_W  = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 1;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

    function automatic logic fp_sign(input logic [FP_W-1:0] f);
        return f[FP_W-1];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] f);
        return f[FP_W-2:MAN_W];
    endfunction

    function automatic logic [MAN_W-1:0] fp_man(input logic [FP_W-1:0] f);
        return f[MAN_W-1:0];
    endfunction
endpackage

// File: rtl/fp_align_shift.sv
// fp_align_shift: right barrel shifter for significand alignment; shifts of 24 or more flush to zero.
module fp_align_shift
    import fp_pkg::*;
(
    input  logic [SIG_W-1:0] sig,
    input  logic [7:0]       amt,
    output logic [SIG_W-1:0] shifted
);
    assign shifted = (amt >= 8'(SIG_W)) ? '0 : sig >> amt;
endmodule

// File: rtl/fp_subtract_seq.sv
// fp_subtract_seq: multi-cycle truncating single-precision A - B behind valid/ready handshakes.
// Normalisation shifts one bit per cycle; zero operands bypass the arithmetic.
module fp_subtract_seq
    import fp_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [FP_W-1:0] A,
    input  logic [FP_W-1:0] B,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [FP_W-1:0] result,
    output logic            out_valid,
    input  logic            out_ready
);
    state_t state, state_nx;
    logic [FP_W-1:0]  a_q, b_q, res_q, x, y;
    logic [SIG_W-1:0] mx_q, my_q, y_sh;
    logic [SIG_W:0]   sig_q;
    logic [EXP_W-1:0] exp_q;
    logic             sign_q, sub_q, out_valid_q;
    logic             a_zero, b_zero, a_big, carry, norm_done;

    assign a_zero    = a_q[FP_W-2:0] == '0;
    assign b_zero    = b_q[FP_W-2:0] == '0;
    assign a_big     = a_q[FP_W-2:0] >= b_q[FP_W-2:0];
    assign x         = a_big ? a_q : b_q;
    assign y         = a_big ? b_q : a_q;
    assign carry     = sig_q[SIG_W];
    assign norm_done = carry || sig_q == '0 || sig_q[MAN_W] || exp_q == '0;

    fp_align_shift u_align (
        .sig     ({1'b1, fp_man(y)}),
        .amt     (fp_exp(x) - fp_exp(y)),
        .shifted (y_sh)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = in_valid ? S_ALIGN : S_IDLE;
            S_ALIGN: state_nx = (a_zero || b_zero) ? S_DONE : S_ADD;
            S_ADD:   state_nx = S_NORM;
            S_NORM:  state_nx = norm_done ? S_DONE : S_NORM;
            S_DONE:  state_nx = (out_valid_q && out_ready) ? S_IDLE : S_DONE;
        endcase
    end

    always_comb in_ready = state == S_IDLE;

    assign result    = res_q;
    assign out_valid = out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            mx_q        <= '0;
            my_q        <= '0;
            sig_q       <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            sub_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // valid rises one cycle after reaching S_DONE so the result register has settled
            out_valid_q <= state == S_DONE && !(out_valid_q && out_ready);
            case (state)
                S_IDLE: if (in_valid) begin
                    a_q <= A;
                    b_q <= {~fp_sign(B), B[FP_W-2:0]};
                end
                S_ALIGN: begin
                    if (a_zero || b_zero) res_q <= a_zero ? (b_zero ? '0 : b_q) : a_q;
                    sign_q <= fp_sign(x);
                    sub_q  <= fp_sign(x) ^ fp_sign(y);
                    exp_q  <= fp_exp(x);
                    mx_q   <= {1'b1, fp_man(x)};
                    my_q   <= y_sh;
                end
                S_ADD: sig_q <= sub_q ? {1'b0, mx_q} - {1'b0, my_q} : {1'b0, mx_q} + {1'b0, my_q};
                S_NORM: begin
                    if (carry)
                        res_q <= (exp_q == EXP_MAX - 8'd1) ? {sign_q, EXP_MAX, {MAN_W{1'b0}}}
                                                           : {sign_q, exp_q + 8'd1, sig_q[MAN_W:1]};
                    else if (sig_q == '0)
                        res_q <= '0;
                    else if (sig_q[MAN_W] || exp_q == '0)
                        res_q <= {sign_q, exp_q, sig_q[MAN_W-1:0]};
                    else begin
                        sig_q <= sig_q << 1;
                        exp_q <= exp_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_subtract_seq.sv
// tb_fp_subtract_seq: directed and randomized A - B transactions against an arithmetic reference,
// with a scoreboard queue drained by an independent output monitor.
module tb_fp_subtract_seq;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] A = '0, B = '0, result;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;

    typedef struct {logic [31:0] res; int lat; int acc;} exp_t;
    exp_t sb[$];
    exp_t cur;
    int   cyc = 0, passed = 0, total = 0;
    bit   rdy_hold = 1'b0, seen = 1'b0;

    fp_subtract_seq dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) out_ready = rdy_hold ? 1'b0 : ($urandom % 4 != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: truncating subtract computed on plain integer significands
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output int lat);
        logic [31:0] bn, x, y;
        int ex, ey, mx, my, s, e, k;
        bn  = {~b[31], b[30:0]};
        lat = 2;
        k   = 0;
        if (a[30:0] == 0) r = (bn[30:0] == 0) ? 32'h0 : bn;
        else if (bn[30:0] == 0) r = a;
        else begin
            x  = (a[30:0] >= bn[30:0]) ? a : bn;
            y  = (a[30:0] >= bn[30:0]) ? bn : a;
            ex = int'(x[30:23]);
            ey = int'(y[30:23]);
            mx = (1 << 23) + int'(x[22:0]);
            my = (1 << 23) + int'(y[22:0]);
            my = (ex - ey >= 24) ? 0 : my >> (ex - ey);
            s  = (x[31] == y[31]) ? mx + my : mx - my;
            e  = ex;
            if (s >= (1 << 24)) begin
                s = s >> 1;
                e = e + 1;
                r = (e == 255) ? {x[31], 8'hFF, 23'h0} : {x[31], 8'(e), 23'(s)};
            end else if (s == 0) r = 32'h0;
            else begin
                while (s < (1 << 23) && e > 0) begin
                    s = s << 1;
                    e = e - 1;
                    k = k + 1;
                end
                r = {x[31], 8'(e), 23'(s)};
            end
            lat = 4 + k;
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && !seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_output: got %h expected none", result);
            end else begin
                cur = sb.pop_front();
                check("result", result, cur.res);
                check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
            end
        end else if (rst_n && out_valid) check("result_hold", result, cur.res);
        else seen = 1'b0;
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input int lat);
        int t = 0;
        @(negedge clk);
        A = a;
        B = b;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end else sb.push_back('{r, lat, cyc + 1});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom), 8'(120 + $urandom_range(0, 15)), 23'($urandom)};
    endfunction

    task automatic issue_rand();
        logic [31:0] a, b, r;
        int lat;
        a = rnd_fp();
        b = rnd_fp();
        case ($urandom % 8)
            0: a = 32'h0;
            1: b = 32'h0;
            2: b = {1'($urandom), a[30:0] ^ 31'($urandom % 256)};
            3: begin
                a = {a[31], 8'hFE, a[22:0]};
                b = {~a[31], 8'hFE, b[22:0]};
            end
            default: ;
        endcase
        model(a, b, r, lat);
        issue(a, b, r, lat);
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'h40400000, 32'h3F800000, 32'h40000000, 4);
        issue(32'h3F800000, 32'h3F800000, 32'h00000000, 4);
        issue(32'h3F800000, 32'h40400000, 32'hC0000000, 4);
        issue(32'h3F800000, 32'hBF800000, 32'h40000000, 4);
        issue(32'h00000000, 32'h40400000, 32'hC0400000, 2);
        issue(32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 27);
        drain();
        // Backpressure: result must hold and extra operands must be ignored
        rdy_hold = 1'b1;
        issue(32'h40400000, 32'h3F800000, 32'h40000000, 4);
        for (int t = 0; t < 60 && !out_valid; t++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            A = $urandom;
            B = $urandom;
            in_valid = 1'b1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_result", result, 32'h40000000);
        end
        in_valid = 1'b0;
        rdy_hold = 1'b0;
        drain();
        // Reset in the middle of a long normalisation
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'd1);
        A = 32'h3F800000;
        B = 32'h3F7FFFFF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", result, 32'h0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'h40400000, 32'h3F800000, 32'h40000000, 4);
        for (int i = 0; i < 150; i++) issue_rand();
        drain();
        repeat (40) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
